// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer write path: VGA timing, wire widths,
// arbiter state encoding and the 3-bit colour type.
package fb_pkg;

  localparam int unsigned H_ACTIVE = 1280;
  localparam int unsigned H_FRONT  = 80;
  localparam int unsigned H_SYNC   = 136;
  localparam int unsigned H_BACK   = 216;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

  localparam int unsigned V_ACTIVE = 960;
  localparam int unsigned V_FRONT  = 1;
  localparam int unsigned V_SYNC   = 3;
  localparam int unsigned V_BACK   = 30;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam int unsigned X_WIRE_WIDTH = $clog2(H_TOTAL);
  localparam int unsigned Y_WIRE_WIDTH = $clog2(V_TOTAL);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_G0   = 2'b01;
  localparam logic [1:0] ST_G1   = 2'b10;

  typedef logic [2:0] rgb_t;

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Bundle of both requester handshakes, FIFO backpressure and the write stream.
// The slave modport is the arbiter side, master is the source/sink side.
interface fb_write_arbiter_if #(
  parameter int unsigned X_WIRE_WIDTH = fb_pkg::X_WIRE_WIDTH,
  parameter int unsigned Y_WIRE_WIDTH = fb_pkg::Y_WIRE_WIDTH
) ();
  import fb_pkg::*;

  logic                    req0_valid;
  logic [X_WIRE_WIDTH-1:0] req0_hpos;
  logic [Y_WIRE_WIDTH-1:0] req0_vpos;
  rgb_t                    req0_RGB;
  logic                    req0_ready;

  logic                    req1_valid;
  logic [X_WIRE_WIDTH-1:0] req1_hpos;
  logic [Y_WIRE_WIDTH-1:0] req1_vpos;
  rgb_t                    req1_RGB;
  logic                    req1_ready;

  logic                    fifofull;
  logic                    display_on;

  logic                    wr_en;
  logic [X_WIRE_WIDTH-1:0] wr_hpos;
  logic [Y_WIRE_WIDTH-1:0] wr_vpos;
  rgb_t                    wr_RGB;
  logic [1:0]              grant;

  modport slave (
    input  req0_valid, req0_hpos, req0_vpos, req0_RGB,
    input  req1_valid, req1_hpos, req1_vpos, req1_RGB,
    input  fifofull, display_on,
    output req0_ready, req1_ready,
    output wr_en, wr_hpos, wr_vpos, wr_RGB, grant
  );

  modport master (
    output req0_valid, req0_hpos, req0_vpos, req0_RGB,
    output req1_valid, req1_hpos, req1_vpos, req1_RGB,
    output fifofull, display_on,
    input  req0_ready, req1_ready,
    input  wr_en, wr_hpos, wr_vpos, wr_RGB, grant
  );

endinterface

// File: rtl/fb_arb_fsm.sv
// Grant state machine: round-robin pointer, burst counter, grant and ready
// generation for the two framebuffer write requesters.
module fb_arb_fsm
  import fb_pkg::*;
#(
  parameter int unsigned BURST_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid_i,
  input  logic       req1_valid_i,
  input  logic       fifofull_i,
  input  logic       display_on_i,
  output logic       req0_ready_o,
  output logic       req1_ready_o,
  output logic [1:0] grant_o
);

  localparam int unsigned CW = $clog2(BURST_MAX + 1);

  logic [1:0]    state_q, state_d;
  logic          ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          open_w;
  logic          own_sel, own_valid, oth_valid, own_xfer, burst_done;

  assign open_w       = ~fifofull_i & display_on_i;
  assign req0_ready_o = (state_q == ST_G0) & open_w;
  assign req1_ready_o = (state_q == ST_G1) & open_w;
  assign grant_o      = (state_q == ST_G0) ? 2'b01 :
                        (state_q == ST_G1) ? 2'b10 : 2'b00;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    own_sel    = 1'b0;
    own_valid  = 1'b0;
    oth_valid  = 1'b0;
    own_xfer   = 1'b0;
    burst_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (req0_valid_i && req1_valid_i) state_d = ptr_q ? ST_G1 : ST_G0;
        else if (req0_valid_i)            state_d = ST_G0;
        else if (req1_valid_i)            state_d = ST_G1;
      end
      ST_G0, ST_G1: begin
        own_sel    = (state_q == ST_G1);
        own_valid  = own_sel ? req1_valid_i : req0_valid_i;
        oth_valid  = own_sel ? req0_valid_i : req1_valid_i;
        own_xfer   = own_valid & open_w;
        burst_done = own_xfer && (cnt_q == CW'(BURST_MAX - 1));
        // Release hands over directly; an exhausted burst with no contender re-enters.
        if (!own_valid || burst_done) begin
          ptr_d = ~own_sel;
          cnt_d = '0;
          if (oth_valid)      state_d = own_sel ? ST_G0 : ST_G1;
          else if (own_valid) state_d = state_q;
          else                state_d = ST_IDLE;
        end else if (own_xfer) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Shares the framebuffer FIFO write port between the ROM streamer and a second
// writer. Define FB_ARB_STATS_EN to add per-requester transfer counters.
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned X_WIRE_WIDTH = fb_pkg::X_WIRE_WIDTH,
  parameter int unsigned Y_WIRE_WIDTH = fb_pkg::Y_WIRE_WIDTH,
  parameter int unsigned BURST_MAX    = 16
`ifdef FB_ARB_STATS_EN
  ,
  parameter int unsigned STAT_WIDTH   = 16
`endif
) (
  input  logic clk,
  input  logic rst,
  fb_write_arbiter_if.slave bus
`ifdef FB_ARB_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] stat_cnt0,
  output logic [STAT_WIDTH-1:0] stat_cnt1
`endif
);

  logic                    req0_ready, req1_ready, xfer0, xfer1;
  logic                    wr_en_q;
  logic [X_WIRE_WIDTH-1:0] wr_hpos_q;
  logic [Y_WIRE_WIDTH-1:0] wr_vpos_q;
  rgb_t                    wr_rgb_q;

  fb_arb_fsm #(.BURST_MAX(BURST_MAX)) u_fsm (
    .clk          (clk),
    .rst          (rst),
    .req0_valid_i (bus.req0_valid),
    .req1_valid_i (bus.req1_valid),
    .fifofull_i   (bus.fifofull),
    .display_on_i (bus.display_on),
    .req0_ready_o (req0_ready),
    .req1_ready_o (req1_ready),
    .grant_o      (bus.grant)
  );

  assign xfer0          = bus.req0_valid & req0_ready;
  assign xfer1          = bus.req1_valid & req1_ready;
  assign bus.req0_ready = req0_ready;
  assign bus.req1_ready = req1_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_q   <= 1'b0;
      wr_hpos_q <= '0;
      wr_vpos_q <= '0;
      wr_rgb_q  <= '0;
    end else begin
      wr_en_q <= xfer0 | xfer1;
      if (xfer0) begin
        wr_hpos_q <= bus.req0_hpos;
        wr_vpos_q <= bus.req0_vpos;
        wr_rgb_q  <= bus.req0_RGB;
      end else if (xfer1) begin
        wr_hpos_q <= bus.req1_hpos;
        wr_vpos_q <= bus.req1_vpos;
        wr_rgb_q  <= bus.req1_RGB;
      end
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_hpos = wr_hpos_q;
  assign bus.wr_vpos = wr_vpos_q;
  assign bus.wr_RGB  = wr_rgb_q;

`ifdef FB_ARB_STATS_EN
  logic [STAT_WIDTH-1:0] stat0_q, stat1_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat0_q <= '0;
      stat1_q <= '0;
    end else begin
      if (xfer0 && (stat0_q != '1)) stat0_q <= stat0_q + 1'b1;
      if (xfer1 && (stat1_q != '1)) stat1_q <= stat1_q + 1'b1;
    end
  end

  assign stat_cnt0 = stat0_q;
  assign stat_cnt1 = stat1_q;
`endif

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: directed scenarios plus random
// traffic, all compared against a transaction-level arbitration model.
module tb_fb_write_arbiter;
  import fb_pkg::*;

  localparam int unsigned XW = X_WIRE_WIDTH;
  localparam int unsigned YW = Y_WIRE_WIDTH;
  localparam int          BM = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fb_write_arbiter_if #(.X_WIRE_WIDTH(XW), .Y_WIRE_WIDTH(YW)) bus ();

`ifdef FB_ARB_STATS_EN
  logic [15:0] stat_cnt0, stat_cnt1;
`endif

  fb_write_arbiter #(.X_WIRE_WIDTH(XW), .Y_WIRE_WIDTH(YW), .BURST_MAX(BM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FB_ARB_STATS_EN
    ,
    .stat_cnt0 (stat_cnt0),
    .stat_cnt1 (stat_cnt1)
`endif
  );

  int vectors = 0;
  int errors  = 0;

  // Reference model: owner -1 = nobody, 0/1 = requester index.
  typedef struct { int own; int ptr; int cnt; bit t0; bit t1; } mstep_t;

  function automatic mstep_t mstep(int own, int ptr, int cnt, bit v0, bit v1, bit ff, bit don);
    mstep_t s;
    bit open_w, vn, vo, tn;
    open_w = !ff && don;
    s.own = own; s.ptr = ptr; s.cnt = cnt;
    s.t0 = v0 && (own == 0) && open_w;
    s.t1 = v1 && (own == 1) && open_w;
    if (own < 0) begin
      s.cnt = 0;
      if (v0 && v1) s.own = ptr;
      else if (v0)  s.own = 0;
      else if (v1)  s.own = 1;
    end else begin
      vn = (own == 0) ? v0 : v1;
      vo = (own == 0) ? v1 : v0;
      tn = s.t0 || s.t1;
      if (!vn || (tn && (cnt + 1 == BM))) begin
        s.ptr = 1 - own;
        s.cnt = 0;
        s.own = vo ? 1 - own : (vn ? own : -1);
      end else begin
        s.cnt = cnt + (tn ? 1 : 0);
      end
    end
    return s;
  endfunction

  int          m_own = -1, m_ptr = 0, m_cnt = 0;
  logic        e_en  = 1'b0;
  logic [XW-1:0] e_h = '0;
  logic [YW-1:0] e_v = '0;
  rgb_t        e_rgb = '0;
  int          e_s0 = 0, e_s1 = 0;
  mstep_t      ms;

  always_comb ms = mstep(m_own, m_ptr, m_cnt, bus.req0_valid, bus.req1_valid,
                         bus.fifofull, bus.display_on);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_own <= -1; m_ptr <= 0; m_cnt <= 0;
      e_en <= 1'b0; e_h <= '0; e_v <= '0; e_rgb <= '0;
      e_s0 <= 0; e_s1 <= 0;
    end else begin
      m_own <= ms.own; m_ptr <= ms.ptr; m_cnt <= ms.cnt;
      e_en  <= ms.t0 | ms.t1;
      if (ms.t0) begin
        e_h <= bus.req0_hpos; e_v <= bus.req0_vpos; e_rgb <= bus.req0_RGB;
      end else if (ms.t1) begin
        e_h <= bus.req1_hpos; e_v <= bus.req1_vpos; e_rgb <= bus.req1_RGB;
      end
      if (ms.t0 && e_s0 < 65535) e_s0 <= e_s0 + 1;
      if (ms.t1 && e_s1 < 65535) e_s1 <= e_s1 + 1;
    end
  end

  function automatic logic [1:0] g_of(int own);
    return (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic r_of(int n);
    return (m_own == n) && !bus.fifofull && bus.display_on;
  endfunction

  task automatic drive(input bit v0, input bit v1, input bit ff, input bit don);
    bus.req0_valid = v0;
    bus.req1_valid = v1;
    bus.fifofull   = ff;
    bus.display_on = don;
    bus.req0_hpos  = XW'($urandom);
    bus.req0_vpos  = YW'($urandom);
    bus.req0_RGB   = rgb_t'($urandom_range(7));
    bus.req1_hpos  = XW'($urandom);
    bus.req1_vpos  = YW'($urandom);
    bus.req1_RGB   = rgb_t'($urandom_range(7));
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(0, 0, 0, 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 1);
    #2 rst = 1'b0;
    #1;
    if ({bus.wr_en, bus.grant, bus.req0_ready, bus.req1_ready} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctl: got en=%b grant=%b rdy=%b%b want 0 00 00",
               bus.wr_en, bus.grant, bus.req0_ready, bus.req1_ready);
    end
    vectors++;
    if ({bus.wr_hpos, bus.wr_vpos, bus.wr_RGB} !== '0) begin
      errors++;
      $display("FAIL reset_data: got h=%0h v=%0h rgb=%0h want 0 0 0",
               bus.wr_hpos, bus.wr_vpos, bus.wr_RGB);
    end
    vectors++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single_source();
    int writes = 0;
    do_reset();
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk);
      if ({bus.wr_en, bus.wr_hpos, bus.wr_vpos, bus.wr_RGB} !== {e_en, e_h, e_v, e_rgb}) begin
        errors++;
        $display("FAIL single_wr cyc=%0d got en=%b h=%0h v=%0h rgb=%0h want en=%b h=%0h v=%0h rgb=%0h",
                 i, bus.wr_en, bus.wr_hpos, bus.wr_vpos, bus.wr_RGB, e_en, e_h, e_v, e_rgb);
      end
      vectors++;
      if (bus.wr_en === 1'b1) writes++;
      drive(i < 40, 0, 0, 1);
      #1;
      if (i >= 1 && i < 40) begin
        if ({bus.grant, bus.req0_ready, bus.req1_ready} !== 4'b0110) begin
          errors++;
          $display("FAIL single_hold cyc=%0d got grant=%b rdy=%b%b want grant=01 rdy=10",
                   i, bus.grant, bus.req0_ready, bus.req1_ready);
        end
        vectors++;
      end
    end
    if (writes !== 39) begin
      errors++;
      $display("FAIL single_count got %0d writes want 39", writes);
    end
    vectors++;
  endtask

  task automatic test_alternate();
    int writes = 0;
    int k = 0;
    do_reset();
    for (int i = 0; i <= 65; i++) begin
      @(negedge clk);
      if ({bus.wr_en, bus.wr_hpos, bus.wr_vpos, bus.wr_RGB} !== {e_en, e_h, e_v, e_rgb}) begin
        errors++;
        $display("FAIL alt_wr cyc=%0d got en=%b h=%0h v=%0h rgb=%0h want en=%b h=%0h v=%0h rgb=%0h",
                 i, bus.wr_en, bus.wr_hpos, bus.wr_vpos, bus.wr_RGB, e_en, e_h, e_v, e_rgb);
      end
      vectors++;
      if (bus.wr_en === 1'b1) writes++;
      drive(i < 65, i < 65, 0, 1);
      #1;
      if (i >= 1 && i <= 64) begin
        k = i - 1;
        if ({bus.req0_ready, bus.req1_ready} !== (((k / 16) % 2 == 0) ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL alt_owner xfer=%0d got rdy=%b%b want source %0d",
                   k, bus.req0_ready, bus.req1_ready, (k / 16) % 2);
        end
        vectors++;
      end
    end
    if (writes !== 64) begin
      errors++;
      $display("FAIL alt_count got %0d writes want 64", writes);
    end
    vectors++;
`ifdef FB_ARB_STATS_EN
    if (stat_cnt0 !== 16'd32 || stat_cnt1 !== 16'd32) begin
      errors++;
      $display("FAIL alt_stats got %0d/%0d want 32/32", stat_cnt0, stat_cnt1);
    end
    vectors++;
`endif
  endtask

  task automatic test_fifofull();
    int r0_after = 0;
    do_reset();
    for (int i = 0; i <= 31; i++) begin
      @(negedge clk);
      if ({bus.wr_en, bus.wr_hpos, bus.wr_vpos, bus.wr_RGB} !== {e_en, e_h, e_v, e_rgb}) begin
        errors++;
        $display("FAIL ff_wr cyc=%0d got en=%b h=%0h want en=%b h=%0h",
                 i, bus.wr_en, bus.wr_hpos, e_en, e_h);
      end
      vectors++;
      if (i >= 5 && i <= 9) begin
        if (bus.wr_en !== 1'b0) begin
          errors++;
          $display("FAIL ff_wren cyc=%0d got %b want 0", i, bus.wr_en);
        end
        vectors++;
      end
      drive(i < 31, i < 31, (i >= 4 && i <= 8), 1);
      #1;
      if (i >= 4 && i <= 8) begin
        if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
          errors++;
          $display("FAIL ff_ready cyc=%0d got %b%b want 00", i, bus.req0_ready, bus.req1_ready);
        end
        vectors++;
      end
      if (i >= 9 && i < 31 && bus.req0_ready === 1'b1) r0_after++;
    end
    if (r0_after !== 13) begin
      errors++;
      $display("FAIL ff_resume got %0d words want 13", r0_after);
    end
    vectors++;
  endtask

  task automatic test_drop();
    bit v0, v1;
    logic [1:0] want;
    do_reset();
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if ({bus.wr_en, bus.wr_hpos, bus.wr_vpos, bus.wr_RGB} !== {e_en, e_h, e_v, e_rgb}) begin
        errors++;
        $display("FAIL drop_wr cyc=%0d got en=%b h=%0h want en=%b h=%0h",
                 i, bus.wr_en, bus.wr_hpos, e_en, e_h);
      end
      vectors++;
      v0 = (i <= 4) || (i == 9);
      v1 = (i <= 7) || (i == 9);
      drive(v0, v1, 0, 1);
      #1;
      if (i == 6 || i == 9 || i == 10) begin
        want = (i == 6) ? 2'b10 : (i == 9) ? 2'b00 : 2'b01;
        if (bus.grant !== want) begin
          errors++;
          $display("FAIL drop_grant cyc=%0d got %b want %b", i, bus.grant, want);
        end
        vectors++;
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i <= 2; i++) begin
      @(negedge clk);
      if ({bus.wr_en, bus.wr_hpos, bus.wr_vpos, bus.wr_RGB} !== {e_en, e_h, e_v, e_rgb}) begin
        errors++;
        $display("FAIL rmid_wr cyc=%0d got en=%b h=%0h want en=%b h=%0h",
                 i, bus.wr_en, bus.wr_hpos, e_en, e_h);
      end
      vectors++;
      drive(i == 2, 1, 0, 1);
    end
    #2 rst = 1'b0;
    #1;
    if ({bus.wr_en, bus.grant, bus.req0_ready, bus.req1_ready,
         bus.wr_hpos, bus.wr_vpos, bus.wr_RGB} !== '0) begin
      errors++;
      $display("FAIL rmid_async got en=%b grant=%b rdy=%b%b h=%0h want all 0",
               bus.wr_en, bus.grant, bus.req0_ready, bus.req1_ready, bus.wr_hpos);
    end
    vectors++;
    @(negedge clk);
    rst = 1'b1;
    #1;
    if (bus.grant !== 2'b00) begin
      errors++;
      $display("FAIL rmid_idle got grant=%b want 00", bus.grant);
    end
    vectors++;
    @(negedge clk);
    #1;
    if ({bus.grant, bus.wr_en} !== 3'b010) begin
      errors++;
      $display("FAIL rmid_first got grant=%b en=%b want grant=01 en=0", bus.grant, bus.wr_en);
    end
    vectors++;
    drive(0, 0, 0, 1);
  endtask

  task automatic test_display_off();
    do_reset();
    for (int i = 0; i <= 14; i++) begin
      @(negedge clk);
      if ({bus.wr_en, bus.wr_hpos, bus.wr_vpos, bus.wr_RGB} !== {e_en, e_h, e_v, e_rgb}) begin
        errors++;
        $display("FAIL don_wr cyc=%0d got en=%b h=%0h want en=%b h=%0h",
                 i, bus.wr_en, bus.wr_hpos, e_en, e_h);
      end
      vectors++;
      if ((i >= 5 && i <= 12) || i == 13) begin
        if (bus.wr_en !== (i == 13)) begin
          errors++;
          $display("FAIL don_wren cyc=%0d got %b want %b", i, bus.wr_en, (i == 13));
        end
        vectors++;
      end
      drive(i < 14, i < 14, 0, !(i >= 4 && i <= 11));
      #1;
      if (i >= 4 && i <= 12) begin
        if ({bus.grant, bus.req0_ready, bus.req1_ready} !== ((i == 12) ? 4'b0110 : 4'b0100)) begin
          errors++;
          $display("FAIL don_hold cyc=%0d got grant=%b rdy=%b%b want grant=01 rdy=%b0",
                   i, bus.grant, bus.req0_ready, bus.req1_ready, (i == 12));
        end
        vectors++;
      end
    end
  endtask

  task automatic test_random();
    bit v0 = 0, v1 = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if ({bus.wr_en, bus.wr_hpos, bus.wr_vpos, bus.wr_RGB} !== {e_en, e_h, e_v, e_rgb}) begin
        errors++;
        $display("FAIL rand_wr cyc=%0d got en=%b h=%0h v=%0h rgb=%0h want en=%b h=%0h v=%0h rgb=%0h",
                 i, bus.wr_en, bus.wr_hpos, bus.wr_vpos, bus.wr_RGB, e_en, e_h, e_v, e_rgb);
      end
      vectors++;
      if ($urandom_range(9) == 0) v0 = !v0;
      if ($urandom_range(9) == 0) v1 = !v1;
      drive(v0, v1, $urandom_range(4) == 0, $urandom_range(9) != 0);
      #1;
      if ({bus.grant, bus.req0_ready, bus.req1_ready} !== {g_of(m_own), r_of(0), r_of(1)}) begin
        errors++;
        $display("FAIL rand_ctl cyc=%0d got grant=%b rdy=%b%b want grant=%b rdy=%b%b",
                 i, bus.grant, bus.req0_ready, bus.req1_ready, g_of(m_own), r_of(0), r_of(1));
      end
      vectors++;
    end
`ifdef FB_ARB_STATS_EN
    @(negedge clk);
    if ({stat_cnt0, stat_cnt1} !== {16'(e_s0), 16'(e_s1)}) begin
      errors++;
      $display("FAIL rand_stats got %0d/%0d want %0d/%0d", stat_cnt0, stat_cnt1, e_s0, e_s1);
    end
    vectors++;
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_source();
    test_alternate();
    test_fifofull();
    test_drop();
    test_reset_mid();
    test_display_off();
    do_reset();
    test_random();
    drive(0, 0, 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
